varredura_display: RTL and testbench

//   Time-multiplexed scan controller for an N-digit 7-segment display sharing one

---
 rtl/varredura_display_if.sv | 11 +
 rtl/varredura_display.sv | 150 +++++++++++++++
 tb/tb_varredura_display.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/varredura_display_if.sv
// rtl/varredura_display_if.sv - frame load handshake between a digit source and the scan controller
interface varredura_display_if #(
  parameter int N_DIG = 4
);
  logic [4*N_DIG-1:0] dado;
  logic               dado_valid;
  logic               dado_ready;

  modport master (output dado, output dado_valid, input dado_ready);
  modport slave  (input dado, input dado_valid, output dado_ready);
endinterface

// File: rtl/varredura_display.sv
// rtl/varredura_display.sv - time-multiplexed scan controller for an N-digit 7-segment display
module varredura_display #(
  parameter int N_DIG    = 4,
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  varredura_display_if.slave    frm,
  input  logic                  supr_zeros,
  output logic [3:0]            bcd,
  output logic [N_DIG-1:0]      an,
  output logic                  quadro
);

  localparam int MAXC = (PRESCALE > BLANK) ? PRESCALE : BLANK;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  typedef enum logic [1:0] {st_idle, st_blank, st_show} st_t;

  st_t                state, state_nx;
  logic [IW-1:0]      idx, idx_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic [4*N_DIG-1:0] shadow, shadow_nx;
  logic [4*N_DIG-1:0] pend, pend_nx;
  logic               pend_full, pend_full_nx;
  logic               quadro_nx;
  logic [3:0]         bcd_nx;
  logic [N_DIG-1:0]   an_nx;
  logic [3:0]         dig;
  logic               supr;

  // State and registered outputs; outputs are derived from next-state values so they
  // take effect in the first cycle of each state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= st_idle;
      idx            <= '0;
      cnt            <= '0;
      shadow         <= '0;
      pend           <= '0;
      pend_full      <= 1'b0;
      bcd            <= 4'h0;
      an             <= '1;
      quadro         <= 1'b0;
      frm.dado_ready <= 1'b1;
    end else begin
      state          <= state_nx;
      idx            <= idx_nx;
      cnt            <= cnt_nx;
      shadow         <= shadow_nx;
      pend           <= pend_nx;
      pend_full      <= pend_full_nx;
      bcd            <= bcd_nx;
      an             <= an_nx;
      quadro         <= quadro_nx;
      frm.dado_ready <= !pend_full_nx;
    end
  end

  // Next state: scan sequencing, frame-boundary shadow swap and pending-frame accept.
  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    cnt_nx       = cnt;
    shadow_nx    = shadow;
    pend_nx      = pend;
    pend_full_nx = pend_full;
    quadro_nx    = 1'b0;

    // A frame waiting while idle is promoted regardless of en.
    if (state == st_idle && pend_full) begin
      shadow_nx    = pend;
      pend_full_nx = 1'b0;
    end

    if (!en) begin
      state_nx = st_idle;
      idx_nx   = '0;
      cnt_nx   = '0;
    end else begin
      case (state)
        st_idle: begin
          state_nx = (BLANK > 0) ? st_blank : st_show;
          idx_nx   = '0;
          cnt_nx   = '0;
        end
        st_blank: begin
          if (int'(cnt) == BLANK - 1) begin
            state_nx = st_show;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        st_show: begin
          if (int'(cnt) == PRESCALE - 1) begin
            cnt_nx   = '0;
            state_nx = (BLANK > 0) ? st_blank : st_show;
            if (int'(idx) == N_DIG - 1) begin
              idx_nx    = '0;
              quadro_nx = 1'b1;
              // Boundary uses pending as it stood before this edge's accept.
              if (pend_full) begin
                shadow_nx    = pend;
                pend_full_nx = 1'b0;
              end
            end else begin
              idx_nx = idx + 1'b1;
            end
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: state_nx = st_idle;
      endcase
    end

    // Ready is !pend_full, so an accept never coincides with a swap out of pending.
    if (frm.dado_valid && !pend_full) begin
      pend_nx      = frm.dado;
      pend_full_nx = 1'b1;
    end
  end

  // Output decode for the upcoming state: digit code, leading-zero suppression, enables.
  always_comb begin
    an_nx  = '1;
    bcd_nx = 4'h0;
    dig    = shadow_nx[4*idx_nx +: 4];
    supr   = 1'b0;
    if (supr_zeros && idx_nx != '0) begin
      supr = 1'b1;
      for (int i = 0; i < N_DIG; i++) begin
        if (i >= int'(idx_nx) && shadow_nx[4*i +: 4] != 4'h0) supr = 1'b0;
      end
    end
    case (state_nx)
      st_blank: bcd_nx = dig;
      st_show: begin
        bcd_nx = dig;
        if (!supr) an_nx[idx_nx] = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_varredura_display.sv
// tb/tb_varredura_display.sv - directed self-checking bench for varredura_display
module tb_varredura_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       supr_zeros = 1'b0;
  logic [3:0] bcd;
  logic [3:0] an;
  logic       quadro;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] shadow_m = 16'h0;
  logic [15:0] pend_m = 16'h0;
  logic        pend_full_m = 1'b0;

  varredura_display_if #(.N_DIG(4)) u_if ();

  varredura_display #(.N_DIG(4), .PRESCALE(4), .BLANK(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .frm        (u_if),
    .supr_zeros (supr_zeros),
    .bcd        (bcd),
    .an         (an),
    .quadro     (quadro)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks one 24-cycle frame starting in its first cycle; optionally offers a new frame at cycle ldk.
  task automatic run_frame(input bit first, input int ldk, input logic [15:0] ld);
    int slot, ph;
    logic [3:0] dig_e, an_e;
    logic [15:0] hi;
    bit sup;
    if (!first && pend_full_m) begin
      shadow_m    = pend_m;
      pend_full_m = 1'b0;
    end
    for (int k = 0; k < 24; k++) begin
      if (k > 0) step();
      slot  = k / 6;
      ph    = k % 6;
      hi    = shadow_m >> (4 * slot);
      dig_e = hi[3:0];
      sup   = supr_zeros && slot >= 1 && hi == 16'h0;
      an_e  = (ph < 2 || sup) ? 4'hF : ~(4'b0001 << slot);
      chk("an", an, an_e);
      chk("bcd", bcd, dig_e);
      chk("quadro", quadro, (k == 0 && !first));
      chk("ready", u_if.dado_ready, !pend_full_m);
      if (k == ldk) begin
        u_if.dado       = ld;
        u_if.dado_valid = 1'b1;
        if (!pend_full_m) begin
          pend_m      = ld;
          pend_full_m = 1'b1;
        end
      end else begin
        u_if.dado_valid = 1'b0;
      end
    end
  endtask

  initial begin
    u_if.dado       = 16'h0;
    u_if.dado_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_an", an, 4'hF);
    chk("rst_bcd", bcd, 4'h0);
    chk("rst_ready", u_if.dado_ready, 1'b1);
    chk("rst_quadro", quadro, 1'b0);
    step();
    rst_n = 1'b1;

    // Idle with en=0
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_an", an, 4'hF);
      chk("idle_bcd", bcd, 4'h0);
      chk("idle_ready", u_if.dado_ready, 1'b1);
      chk("idle_quadro", quadro, 1'b0);
    end

    // Load 1234 while idle
    u_if.dado       = 16'h1234;
    u_if.dado_valid = 1'b1;
    step();
    u_if.dado_valid = 1'b0;
    chk("load_ready_lo", u_if.dado_ready, 1'b0);
    step();
    chk("load_ready_hi", u_if.dado_ready, 1'b1);
    shadow_m = 16'h1234;

    en = 1'b1;
    step();
    run_frame(1'b1, -1, 16'h0);
    step();
    run_frame(1'b0, 5, 16'h5678);
    step();
    run_frame(1'b0, 3, 16'h0007);

    // Leading-zero suppression
    supr_zeros = 1'b1;
    step();
    run_frame(1'b0, 10, 16'h0A00);
    step();
    run_frame(1'b0, -1, 16'h0);

    // en=0 during SHOW of idx 2
    step();
    for (int i = 0; i < 14; i++) step();
    chk("show2_an", an, 4'b1011);
    en = 1'b0;
    step();
    chk("stop_an", an, 4'hF);
    chk("stop_quadro", quadro, 1'b0);
    en = 1'b1;
    supr_zeros = 1'b0;
    step();
    run_frame(1'b1, -1, 16'h0);

    // Async reset mid-SHOW with a frame pending
    step();
    u_if.dado       = 16'h9999;
    u_if.dado_valid = 1'b1;
    step();
    u_if.dado_valid = 1'b0;
    chk("pend_ready_lo", u_if.dado_ready, 1'b0);
    step();
    step();
    chk("mid_show_an", an, 4'b1110);
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    chk("arst_an", an, 4'hF);
    chk("arst_bcd", bcd, 4'h0);
    chk("arst_ready", u_if.dado_ready, 1'b1);
    chk("arst_quadro", quadro, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_ready", u_if.dado_ready, 1'b1);
    chk("post_rst_an", an, 4'hF);
    shadow_m    = 16'h0;
    pend_full_m = 1'b0;
    en = 1'b1;
    step();
    run_frame(1'b1, -1, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
